regfile_ckpt: RTL

Parametrised successor to the core's architectural register file and rename table (RAT), sitting between IDU, ROB and the dispatch stage.
- Adds NRD flattened read ports and hard-wired x0.
- Adds a circular buffer of NCK RAT checkpoints for single-cycle branch-mispredict recovery, alongside the existing full-flush rollback.
- ROB tag 0 (`ZERO_ROB_IDX) means "value ready in val[]", as elsewhere in the core.

---
 rtl/regfile_ckpt_pkg.sv | 24 ++
 rtl/rat_snapshot_buf.sv | 96 +++++++++
 rtl/regfile_ckpt.sv | 99 +++++++++
 3 files changed

// File: rtl/regfile_ckpt_pkg.sv
// Shared types for the register file / rename table with RAT checkpoints.
// cyc_decode fixes the cycle priority so the top and the snapshot buffer agree.
package regfile_ckpt_pkg;
  localparam int NREG = 32;
  localparam int XLEN = 32;

  typedef logic [4:0]      reg_idx_t;
  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [1:0] {
    CYC_HOLD,
    CYC_FLUSH,
    CYC_RESTORE,
    CYC_NORMAL
  } cyc_e;

  // Reset is handled separately in each always_ff and outranks this decode.
  function automatic cyc_e cyc_decode(input logic rb, input logic hold, input logic restore);
    if (rb)      return CYC_FLUSH;
    if (hold)    return CYC_HOLD;
    if (restore) return CYC_RESTORE;
    return CYC_NORMAL;
  endfunction
endpackage

// File: rtl/rat_snapshot_buf.sv
// Circular buffer of RAT checkpoints: owns the snapshot array, head/tail/count
// pointers and the commit-clear broadcast into every live slot.
module rat_snapshot_buf
  import regfile_ckpt_pkg::*;
#(
  parameter int ROB_BIT = 4,
  parameter int NCK     = 4,
  parameter int CK_BIT  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  cyc_e                            cyc,
  input  logic                            save,
  input  logic                            rel,
  input  logic [NREG-1:0][ROB_BIT-1:0]    save_rat,
  input  logic [CK_BIT-1:0]               restore_id,
  output logic [NREG-1:0][ROB_BIT-1:0]    restore_rat,
  input  logic                            cm_ena,
  input  reg_idx_t                        cm_rd,
  input  logic [ROB_BIT-1:0]              cm_idx,
  output logic [CK_BIT-1:0]               tail,
  output logic                            full
);
  logic [NCK-1:0][NREG-1:0][ROB_BIT-1:0] snap;
  logic [CK_BIT-1:0] head;
  logic [CK_BIT:0]   count;
  logic [NCK-1:0]    live;
  logic [NCK-1:0]    clr;
  logic              rel_ok;
  logic              save_ok;
  logic [CK_BIT:0]   cnt_rel;
  logic [CK_BIT:0]   cnt_rs;
  logic [CK_BIT-1:0] rs_off;

  for (genvar k = 0; k < NCK; k++) begin : g_slot
    logic [CK_BIT-1:0] off;
    assign off     = CK_BIT'(k) - head;
    assign live[k] = {1'b0, off} < count;
    assign clr[k]  = cm_ena && live[k] && (snap[k][cm_rd] == cm_idx);
  end

  always_comb begin
    restore_rat = snap[restore_id];
    if (cm_ena && restore_rat[cm_rd] == cm_idx) restore_rat[cm_rd] = '0;
  end

  always_comb begin
    rel_ok  = rel && (count != '0);
    cnt_rel = count - (CK_BIT+1)'(rel_ok);
    save_ok = save && (cnt_rel != (CK_BIT+1)'(NCK));
    rs_off  = restore_id - head;
    // Slots head..restore_id stay live; a same-cycle release drops the oldest.
    cnt_rs  = {1'b0, rs_off} + (CK_BIT+1)'(1) - (CK_BIT+1)'(rel_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      case (cyc)
        CYC_FLUSH: begin
          head  <= '0;
          tail  <= '0;
          count <= '0;
        end
        CYC_RESTORE: begin
          head  <= head + CK_BIT'(rel_ok);
          tail  <= restore_id + CK_BIT'(1);
          count <= cnt_rs;
        end
        CYC_NORMAL: begin
          head  <= head + CK_BIT'(rel_ok);
          tail  <= tail + CK_BIT'(save_ok);
          count <= cnt_rel + (CK_BIT+1)'(save_ok);
        end
        default: ;
      endcase
    end
  end

  // Snapshot data needs no reset: a slot is only read back while live.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NCK; k++) begin
      if ((cyc == CYC_RESTORE || cyc == CYC_NORMAL) && clr[k]) snap[k][cm_rd] <= '0;
      if (cyc == CYC_NORMAL && save_ok && tail == CK_BIT'(k)) snap[k] <= save_rat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && cyc == CYC_RESTORE) assert (live[restore_id]);
  end

  assign full = (count == (CK_BIT+1)'(NCK));
endmodule

// File: rtl/regfile_ckpt.sv
// Architectural register file plus live rename table with flattened read ports,
// hard-wired x0 and single-cycle checkpoint restore for mispredict recovery.
module regfile_ckpt
  import regfile_ckpt_pkg::*;
#(
  parameter int NRD     = 4,
  parameter int ROB_BIT = 4,
  parameter int NCK     = 4,
  parameter int CK_BIT  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    reg_en,
  input  logic                    reg_st,
  input  logic                    reg_rb,
  input  logic [NRD*5-1:0]        id_rs,
  output logic [NRD*ROB_BIT-1:0]  id_src,
  output logic [NRD*32-1:0]       id_val,
  input  logic                    id_rn_ena,
  input  logic [4:0]              id_rn_rd,
  input  logic [ROB_BIT-1:0]      id_rn_idx,
  input  logic                    ck_save,
  output logic [CK_BIT-1:0]       ck_tag,
  output logic                    ck_full,
  input  logic                    ck_release,
  input  logic                    ck_restore,
  input  logic [CK_BIT-1:0]       ck_restore_id,
  input  logic                    rob_wr_ena,
  input  logic [4:0]              rob_wr_rd,
  input  logic [31:0]             rob_wr_val,
  input  logic [ROB_BIT-1:0]      rob_wr_idx
);
  logic [NREG-1:0][ROB_BIT-1:0] src;
  logic [NREG-1:0][ROB_BIT-1:0] rat_cm;
  logic [NREG-1:0][ROB_BIT-1:0] rat_nx;
  logic [NREG-1:0][ROB_BIT-1:0] restore_rat;
  logic [NREG-1:0][XLEN-1:0]    val;
  cyc_e                         cyc;

  assign cyc = cyc_decode(reg_rb, !rdy || !reg_en || reg_st, ck_restore);

  // Commit clear first, then rename; a same-register rename wins.
  always_comb begin
    rat_cm = src;
    if (rob_wr_ena && src[rob_wr_rd] == rob_wr_idx) rat_cm[rob_wr_rd] = '0;
    rat_nx = rat_cm;
    if (id_rn_ena && id_rn_rd != '0) rat_nx[id_rn_rd] = id_rn_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src <= '0;
      val <= '0;
    end else begin
      if (cyc != CYC_HOLD && rob_wr_ena && rob_wr_rd != '0) val[rob_wr_rd] <= rob_wr_val;
      case (cyc)
        CYC_FLUSH:   src <= '0;
        CYC_RESTORE: src <= restore_rat;
        CYC_NORMAL:  src <= rat_nx;
        default: ;
      endcase
    end
  end

  rat_snapshot_buf #(
    .ROB_BIT(ROB_BIT),
    .NCK    (NCK),
    .CK_BIT (CK_BIT)
  ) u_snap (
    .clk        (clk),
    .rst        (rst),
    .cyc        (cyc),
    .save       (ck_save),
    .rel        (ck_release),
    .save_rat   (rat_nx),
    .restore_id (ck_restore_id),
    .restore_rat(restore_rat),
    .cm_ena     (rob_wr_ena),
    .cm_rd      (rob_wr_rd),
    .cm_idx     (rob_wr_idx),
    .tail       (ck_tag),
    .full       (ck_full)
  );

  // Read ports bypass the rename and commit of the current cycle, even when stalled.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    reg_idx_t rs;
    logic     cm_hit;
    assign rs     = id_rs[5*k +: 5];
    assign cm_hit = rob_wr_ena && (rob_wr_rd == rs) && (rob_wr_idx == src[rs]);
    assign id_src[ROB_BIT*k +: ROB_BIT] =
      (rs == '0)                        ? '0        :
      (id_rn_ena && id_rn_rd == rs)     ? id_rn_idx :
      cm_hit                            ? '0        : src[rs];
    assign id_val[32*k +: 32] =
      (rs == '0) ? '0 : cm_hit ? rob_wr_val : val[rs];
  end
endmodule
